// File: rtl/spiflash_pkg.sv
// Shared definitions for the SPI flash responder: command opcodes,
// responder states and the JEDEC ID byte selector.
package spiflash_pkg;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_RDID = 8'h9F;
  localparam logic [7:0] CMD_RDSR = 8'h05;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    ID,
    STAT,
    IGNORE
  } state_t;

  // Byte idx of the ID response: 0..2 walk the JEDEC ID MSB first, then zeros.
  function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [2:0] idx);
    case (idx)
      3'd0:    id_byte = id[23:16];
      3'd1:    id_byte = id[15:8];
      3'd2:    id_byte = id[7:0];
      default: id_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous SPI pin plus a third flop that
// turns the synchronised level into single-cycle rise/fall strobes.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic meta_q;
  logic sync_q;
  logic last_q;

  // Synchroniser chain; all stages reset to the pin's idle level.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      last_q <= RESET_VAL;
    end else begin
      meta_q <= i_pin;
      sync_q <= meta_q;
      last_q <= sync_q;
    end
  end

  assign o_level = sync_q;
  assign o_rise  = sync_q & ~last_q;
  assign o_fall  = ~sync_q & last_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 responder emulating a serial NOR flash: READ (0x03) streams
// bytes from a host memory port, RDID (0x9F) returns the JEDEC ID and RDSR
// (0x05) returns a fixed status byte. All SPI pins are oversampled by i_clk.
//
// Memory port: o_rd_req is a one-cycle strobe qualifying o_rd_addr; there is
// no back-pressure, and i_rd_data must be valid exactly one i_clk after the
// cycle in which o_rd_req is high.
module spi_flash_responder
  import spiflash_pkg::*;
#(
  parameter int          ADDR_BITS   = 24,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
  parameter logic [7:0]  STATUS_BYTE = 8'h00
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_spi_cs_n,
  input  logic                 i_spi_sck,
  input  logic                 i_spi_mosi,
  output logic                 o_spi_miso,
  output logic                 o_spi_miso_oe,
  output logic                 o_rd_req,
  output logic [ADDR_BITS-1:0] o_rd_addr,
  input  logic [7:0]           i_rd_data,
  output logic [7:0]           o_cmd,
  output logic                 o_busy
);

  localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  // Synchronised pins
  logic cs_sync, cs_rise_unused, cs_fall_unused;
  logic sck_rise, sck_fall, sck_level_unused;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
    .i_clk(i_clk), .i_reset(i_reset), .i_pin(i_spi_cs_n),
    .o_level(cs_sync), .o_rise(cs_rise_unused), .o_fall(cs_fall_unused)
  );

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sck (
    .i_clk(i_clk), .i_reset(i_reset), .i_pin(i_spi_sck),
    .o_level(sck_level_unused), .o_rise(sck_rise), .o_fall(sck_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
    .i_clk(i_clk), .i_reset(i_reset), .i_pin(i_spi_mosi),
    .o_level(mosi_sync), .o_rise(mosi_rise_unused), .o_fall(mosi_fall_unused)
  );

  // State and datapath registers
  state_t      state, state_nxt;
  logic [2:0]  bit_cnt;
  logic [1:0]  byte_idx;
  logic [22:0] shift_in;
  logic [23:0] shift_next;
  logic [7:0]  tx_sr;
  logic [7:0]  prefetch;
  logic        rd_vld;
  logic [1:0]  settle;
  logic        armed;

  // Decoded phase flags
  logic cmd_phase, addr_phase, data_phase, id_phase, stat_phase, resp_phase;

  // Incoming MOSI bit appended to everything shifted so far in this command.
  assign shift_next = {shift_in, mosi_sync};
  assign o_busy     = ~cs_sync;

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state: CS high always wins and returns to IDLE.
  always_comb begin
    state_nxt = state;
    if (state == IDLE) begin
      if (armed && !cs_sync) state_nxt = CMD;
    end else if (cs_sync) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        CMD: begin
          if (sck_rise && bit_cnt == 3'd7) begin
            case (shift_next[7:0])
              CMD_READ: state_nxt = ADDR;
              CMD_RDID: state_nxt = ID;
              CMD_RDSR: state_nxt = STAT;
              default:  state_nxt = IGNORE;
            endcase
          end
        end
        // The first byte has arrived from memory; start streaming.
        ADDR:    if (rd_vld) state_nxt = DATA;
        default: state_nxt = state;
      endcase
    end
  end

  // Phase decode used by the datapath.
  always_comb begin
    cmd_phase  = (state == CMD);
    addr_phase = (state == ADDR);
    data_phase = (state == DATA);
    id_phase   = (state == ID);
    stat_phase = (state == STAT);
    resp_phase = data_phase | id_phase | stat_phase;
  end

  // Datapath: MOSI capture on sck rise, MISO shifting on sck fall, memory fetches.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_spi_miso    <= 1'b0;
      o_spi_miso_oe <= 1'b0;
      o_rd_req      <= 1'b0;
      o_rd_addr     <= '0;
      o_cmd         <= 8'h00;
      bit_cnt       <= 3'd0;
      byte_idx      <= 2'd0;
      shift_in      <= '0;
      tx_sr         <= 8'h00;
      prefetch      <= 8'h00;
      rd_vld        <= 1'b0;
      settle        <= 2'd0;
      armed         <= 1'b0;
    end else begin
      o_rd_req <= 1'b0;
      rd_vld   <= o_rd_req;

      // After reset the CS synchroniser holds its reset value for two cycles;
      // only a genuinely observed CS-high may arm the responder.
      if (settle != 2'd3) settle <= settle + 2'd1;
      if (settle == 2'd3 && cs_sync) armed <= 1'b1;

      if (state == IDLE || cs_sync) begin
        bit_cnt       <= 3'd0;
        byte_idx      <= 2'd0;
        o_spi_miso    <= 1'b0;
        o_spi_miso_oe <= 1'b0;
      end else begin
        if (sck_rise) begin
          bit_cnt  <= bit_cnt + 3'd1;
          shift_in <= shift_next[22:0];
          if (cmd_phase && bit_cnt == 3'd7) begin
            o_cmd    <= shift_next[7:0];
            byte_idx <= 2'd0;
            if (shift_next[7:0] == CMD_RDID) tx_sr <= id_byte(JEDEC_ID, 3'd0);
            if (shift_next[7:0] == CMD_RDSR) tx_sr <= STATUS_BYTE;
          end
          if (addr_phase && bit_cnt == 3'd7) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd2) begin
              o_rd_addr <= shift_next[ADDR_BITS-1:0];
              o_rd_req  <= 1'b1;
            end
          end
        end

        if (sck_fall && resp_phase) begin
          o_spi_miso    <= tx_sr[7];
          o_spi_miso_oe <= 1'b1;
          tx_sr         <= {tx_sr[6:0], 1'b0};
          // Bit 7 of a byte is leaving: fetch the byte after it.
          if (data_phase && bit_cnt == 3'd0) begin
            o_rd_addr <= o_rd_addr + ADDR_ONE;
            o_rd_req  <= 1'b1;
          end
          // Bit 0 is leaving: queue up the next byte.
          if (bit_cnt == 3'd7) begin
            if (data_phase) tx_sr <= prefetch;
            if (stat_phase) tx_sr <= STATUS_BYTE;
            if (id_phase) begin
              tx_sr <= id_byte(JEDEC_ID, {1'b0, byte_idx} + 3'd1);
              if (byte_idx != 2'd3) byte_idx <= byte_idx + 2'd1;
            end
          end
        end

        if (rd_vld && addr_phase) tx_sr    <= i_rd_data;
        if (rd_vld && data_phase) prefetch <= i_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: drives SPI mode-0 transactions,
// models the flash responses and the memory, and checks MISO bytes, memory
// fetch addresses and the MISO output enable.
module tb_spi_flash_responder;

  localparam int          HALF   = 5;
  localparam logic [23:0] JEDEC  = 24'hEF4018;
  localparam logic [7:0]  STATUS = 8'h00;

  // Clock/reset and DUT signals
  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        cs_n, sck, mosi;
  logic        miso, miso_oe, rd_req, busy;
  logic [23:0] rd_addr;
  logic [7:0]  rd_data = 8'h00;
  logic [7:0]  cmd;

  int checks   = 0;
  int failures = 0;

  logic        oe_ok = 1'b0;
  logic [23:0] exp_addr_q[$];
  logic [23:0] exp_addr;
  logic [7:0]  got [8];

  always #5 i_clk = ~i_clk;

  spi_flash_responder dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_spi_cs_n(cs_n),
    .i_spi_sck(sck),
    .i_spi_mosi(mosi),
    .o_spi_miso(miso),
    .o_spi_miso_oe(miso_oe),
    .o_rd_req(rd_req),
    .o_rd_addr(rd_addr),
    .i_rd_data(rd_data),
    .o_cmd(cmd),
    .o_busy(busy)
  );

  // Memory contents: mem[a] = a[7:0], one-cycle read latency.
  always @(posedge i_clk) if (rd_req) rd_data <= rd_addr[7:0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Response byte k of a command, derived from the flash behaviour.
  function automatic logic [7:0] model_byte(input logic [7:0] c, input logic [23:0] a, input int k);
    logic [23:0] ak;
    logic [23:0] id;
    ak = a + 24'(k);
    id = JEDEC << (8 * k);
    case (c)
      8'h03:   return ak[7:0];
      8'h9F:   return (k < 3) ? id[23:16] : 8'h00;
      8'h05:   return STATUS;
      default: return 8'h00;
    endcase
  endfunction

  // Per-cycle compare: every fetch matches the expected address sequence,
  // and MISO is never enabled outside a response window.
  always @(negedge i_clk) begin
    if (rd_req === 1'b1) begin
      checks++;
      if (exp_addr_q.size() == 0) begin
        failures++;
        $display("FAIL rd_req: unexpected read at 0x%0h, no read expected", rd_addr);
      end else begin
        exp_addr = exp_addr_q.pop_front();
        if (rd_addr !== exp_addr) begin
          failures++;
          $display("FAIL rd_addr: got 0x%0h expected 0x%0h", rd_addr, exp_addr);
        end
      end
    end
    if (!oe_ok) begin
      checks++;
      if (miso_oe !== 1'b0) begin
        failures++;
        $display("FAIL miso_oe_idle: got %b expected 0", miso_oe);
      end
    end
  end

  // Driver: one SPI bit; SCK falls (data change), then rises (sample).
  task automatic clk_bit(input logic b, output logic r, output logic o);
    sck  = 1'b0;
    mosi = b;
    repeat (HALF) @(negedge i_clk);
    r   = miso;
    o   = miso_oe;
    sck = 1'b1;
    repeat (HALF) @(negedge i_clk);
  endtask

  task automatic send_bits(input logic [23:0] v, input int n);
    logic r, o;
    for (int i = n - 1; i >= 0; i--) clk_bit(v[i], r, o);
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    repeat (HALF) @(negedge i_clk);
    check("busy_in_cs", busy, 1);
  endtask

  // SCK returns low together with CS rising.
  task automatic cs_high();
    sck  = 1'b0;
    cs_n = 1'b1;
    repeat (6) @(negedge i_clk);
    oe_ok = 1'b0;
    check("oe_after_cs", miso_oe, 0);
    check("busy_after_cs", busy, 0);
    repeat (HALF) @(negedge i_clk);
  endtask

  task automatic txn(input logic [7:0] c, input logic [23:0] a, input int n);
    logic       r, o, oe_all, known;
    logic [7:0] b;
    known = (c == 8'h03) || (c == 8'h9F) || (c == 8'h05);
    if (c == 8'h03)
      for (int k = 0; k <= n; k++) exp_addr_q.push_back(a + 24'(k));
    cs_low();
    send_bits({16'h0000, c}, 8);
    if (c == 8'h03) send_bits(a, 24);
    oe_ok = known;
    for (int k = 0; k < n; k++) begin
      oe_all = 1'b1;
      for (int i = 7; i >= 0; i--) begin
        clk_bit(1'b0, r, o);
        b[i]   = r;
        oe_all = oe_all & o;
      end
      got[k] = b;
      if (known) begin
        check($sformatf("miso_cmd%02h_byte%0d", c, k), b, model_byte(c, a, k));
        check("oe_in_response", oe_all, 1);
      end
    end
    check("o_cmd", cmd, c);
    cs_high();
    // The fetch one past the last clocked byte is optional.
    if (c == 8'h03 && exp_addr_q.size() == 1 && exp_addr_q[0] == a + 24'(n))
      void'(exp_addr_q.pop_front());
    check("rd_queue_drained", exp_addr_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_miso"}, miso, 0);
    check({tag, "_oe"}, miso_oe, 0);
    check({tag, "_rd_req"}, rd_req, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_cmd"}, cmd, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Watchdog
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r, o;
    i_reset = 1'b1;
    cs_n    = 1'b1;
    sck     = 1'b0;
    mosi    = 1'b0;
    repeat (3) @(negedge i_clk);
    check_reset_vals("reset");
    i_reset = 1'b0;
    repeat (10) @(negedge i_clk);

    // READ 4 bytes from 0x000010
    txn(8'h03, 24'h000010, 4);
    check("read_lit_b0", got[0], 8'h10);
    check("read_lit_b3", got[3], 8'h13);

    // JEDEC ID, 5 bytes
    txn(8'h9F, 24'h0, 5);
    check("id_lit_b0", got[0], 8'hEF);
    check("id_lit_b1", got[1], 8'h40);
    check("id_lit_b2", got[2], 8'h18);
    check("id_lit_b4", got[4], 8'h00);
    check("id_lit_cmd", cmd, 8'h9F);

    // Status, 3 bytes
    txn(8'h05, 24'h0, 3);
    check("stat_lit_b2", got[2], 8'h00);

    // Address wrap
    txn(8'h03, 24'hFFFFFF, 2);
    check("wrap_lit_b0", got[0], 8'hFF);
    check("wrap_lit_b1", got[1], 8'h00);

    // Abort after 13 address bits, then a clean READ
    cs_low();
    send_bits(24'h000003, 8);
    send_bits(24'hA5C3F0 >> 11, 13);
    cs_high();
    txn(8'h03, 24'h000020, 2);
    check("abort_lit_b0", got[0], 8'h20);

    // Unknown command: no oe, no reads
    txn(8'hAB, 24'h0, 2);
    check("unknown_lit_cmd", cmd, 8'hAB);

    // Reset mid-DATA
    exp_addr_q.push_back(24'h000040);
    exp_addr_q.push_back(24'h000041);
    exp_addr_q.push_back(24'h000042);
    cs_low();
    send_bits(24'h000003, 8);
    send_bits(24'h000040, 24);
    oe_ok = 1'b1;
    for (int i = 0; i < 11; i++) clk_bit(1'b0, r, o);
    check("pre_reset_oe", miso_oe, 1);
    check("pre_reset_busy", busy, 1);
    #3;
    i_reset = 1'b1;
    oe_ok   = 1'b0;
    exp_addr_q.delete();
    #1;
    check_reset_vals("async_reset");
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    repeat (4) @(negedge i_clk);
    // CS still low from before reset: this traffic must be ignored.
    send_bits({8'h00, 8'h9F, 8'h00}, 16);
    check("ignored_after_reset_cmd", cmd, 0);
    cs_high();
    txn(8'h05, 24'h0, 2);
    txn(8'h03, 24'h000080, 1);
    check("recover_lit_b0", got[0], 8'h80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
